// File: rtl/norm_shift_resp_if.sv
// rtl/norm_shift_resp_if.sv - ready/done request bus between a calling FSM and the normalise/shift responder
interface norm_shift_resp_if;
  logic        ready;
  logic        mode;
  logic [31:0] var1;
  logic [15:0] numShift;
  logic        done;
  logic        busy;
  logic [15:0] norm;
  logic [31:0] out;
  logic        overflow;

  modport master (
    output ready, mode, var1, numShift,
    input  done, busy, norm, out, overflow
  );

  modport slave (
    input  ready, mode, var1, numShift,
    output done, busy, norm, out, overflow
  );
endinterface

// File: rtl/norm_shift_resp.sv
// rtl/norm_shift_resp.sv - bit-serial norm_l / saturating L_shl-L_shr responder, one 1-bit shift per clock
module norm_shift_resp #(
  parameter int MAX_RSHIFT = 31
) (
  input  logic             clk,
  input  logic             reset,
  norm_shift_resp_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_SHIFT, S_DONE} state_t;

  localparam logic [16:0] RMAX_WIDE = 17'(MAX_RSHIFT);
  localparam logic [5:0]  RMAX      = 6'(MAX_RSHIFT);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        right_q, right_d;
  logic        sign_q, sign_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [15:0] norm_q, norm_d;
  logic [31:0] out_q, out_d;
  logic        overflow_q, overflow_d;

  logic [16:0] n_abs;
  logic [5:0]  n_left;
  logic [5:0]  n_right;

  // Magnitude needs 17 bits so that -32768 is represented.
  always_comb begin
    n_abs   = bus.numShift[15] ? (17'd0 - {bus.numShift[15], bus.numShift})
                               : {1'b0, bus.numShift};
    n_left  = (n_abs > 17'd32) ? 6'd32 : n_abs[5:0];
    n_right = (n_abs > RMAX_WIDE) ? RMAX : n_abs[5:0];
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    right_d    = right_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    norm_d     = norm_q;
    out_d      = out_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ready) begin
          acc_d  = bus.var1;
          mode_d = bus.mode;
          sign_d = bus.var1[31];
          ovf_d  = 1'b0;
          if (!bus.mode) begin
            cnt_d   = 6'd0;
            right_d = 1'b0;
            state_d = S_NORM;
          end else begin
            // In shift mode the counter holds the remaining step count.
            right_d = bus.numShift[15];
            cnt_d   = bus.numShift[15] ? n_right : n_left;
            state_d = S_SHIFT;
          end
        end
      end

      S_NORM: begin
        if (acc_q == 32'd0) begin
          cnt_d   = 6'd0;
          state_d = S_DONE;
        end else if (acc_q == 32'hFFFF_FFFF) begin
          acc_d   = 32'h8000_0000;
          cnt_d   = 6'd31;
          state_d = S_DONE;
        end else if (acc_q[31] == acc_q[30]) begin
          acc_d = {acc_q[30:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d = S_DONE;
        end
      end

      S_SHIFT: begin
        if (cnt_q == 6'd0) begin
          state_d = S_DONE;
        end else if (right_q) begin
          acc_d = {acc_q[31], acc_q[31:1]};
          cnt_d = cnt_q - 6'd1;
        end else if ((acc_q != 32'd0) && (acc_q[31] != acc_q[30])) begin
          // Next left shift would flip the sign: clamp toward the operand's sign.
          acc_d   = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d = {acc_q[30:0], 1'b0};
          cnt_d = cnt_q - 6'd1;
        end
      end

      S_DONE: begin
        done_d     = 1'b1;
        out_d      = acc_q;
        norm_d     = mode_q ? 16'd0 : {10'd0, cnt_q};
        overflow_d = ovf_q;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      acc_q      <= 32'd0;
      cnt_q      <= 6'd0;
      mode_q     <= 1'b0;
      right_q    <= 1'b0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      norm_q     <= 16'd0;
      out_q      <= 32'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      right_q    <= right_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      norm_q     <= norm_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.busy     = (state_q == S_NORM) || (state_q == S_SHIFT);
  assign bus.norm     = norm_q;
  assign bus.out      = out_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_norm_shift_resp.sv
// tb/tb_norm_shift_resp.sv - directed vector bench for norm_shift_resp
module tb_norm_shift_resp;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  norm_shift_resp_if bus_if ();

  norm_shift_resp #(.MAX_RSHIFT(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] var1;
    logic [15:0] nsh;
    logic [31:0] exp_out;
    logic [15:0] exp_norm;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Launch one request; latency counts edges after the accepting edge until done is seen.
  task automatic do_op(input logic m, input logic [31:0] v, input logic [15:0] n,
                       output int lat, output logic bz_start, output logic bz_done,
                       output logic [31:0] o, output logic [15:0] nr, output logic ov,
                       output logic done_after);
    bus_if.mode     = m;
    bus_if.var1     = v;
    bus_if.numShift = n;
    bus_if.ready    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.ready = 1'b0;
    bz_start = bus_if.busy;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin
        lat = i;
        break;
      end
    end
    bz_done = bus_if.busy;
    o  = bus_if.out;
    nr = bus_if.norm;
    ov = bus_if.overflow;
    @(posedge clk);
    #1;
    done_after = bus_if.done;
  endtask

  int          lat;
  int          total;
  int          extra_done;
  logic        bz_s, bz_d, ov, da;
  logic [31:0] o;
  logic [15:0] nr;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus_if.ready    = 1'b0;
    bus_if.mode     = 1'b0;
    bus_if.var1     = 32'd0;
    bus_if.numShift = 16'd0;

    vecs[0]  = '{1'b0, 32'h0001_0000, 16'd0,     32'h4000_0000, 16'd14, 1'b0, 16};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 16'd0,     32'h8000_0000, 16'd31, 1'b0, 2};
    vecs[2]  = '{1'b0, 32'h0000_0000, 16'd0,     32'h0000_0000, 16'd0,  1'b0, 2};
    vecs[3]  = '{1'b1, 32'h0000_4000, 16'd3,     32'h0002_0000, 16'd0,  1'b0, 5};
    vecs[4]  = '{1'b1, 32'h1234_5678, 16'd0,     32'h1234_5678, 16'd0,  1'b0, 2};
    vecs[5]  = '{1'b1, 32'h4000_0000, 16'd2,     32'h7FFF_FFFF, 16'd0,  1'b1, 2};
    vecs[6]  = '{1'b1, 32'hC000_0001, 16'd5,     32'h8000_0000, 16'd0,  1'b1, 3};
    vecs[7]  = '{1'b1, 32'h8000_0000, 16'hFFD8,  32'hFFFF_FFFF, 16'd0,  1'b0, 33};
    vecs[8]  = '{1'b1, 32'h0000_0100, 16'hFFFC,  32'h0000_0010, 16'd0,  1'b0, 6};
    vecs[9]  = '{1'b0, 32'h0000_0001, 16'd0,     32'h4000_0000, 16'd30, 1'b0, 32};
    vecs[10] = '{1'b1, 32'h0000_0001, 16'd40,    32'h7FFF_FFFF, 16'd0,  1'b1, 32};
    vecs[11] = '{1'b0, 32'hFFFF_8000, 16'd0,     32'h8000_0000, 16'd16, 1'b0, 18};
    vecs[12] = '{1'b1, 32'h8000_0000, 16'hFFFF,  32'hC000_0000, 16'd0,  1'b0, 3};
    vecs[13] = '{1'b1, 32'hFFFF_FFFF, 16'd3,     32'hFFFF_FFF8, 16'd0,  1'b0, 5};
    vecs[14] = '{1'b1, 32'h1234_5678, 16'h8000,  32'h0000_0000, 16'd0,  1'b0, 33};

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done",     {31'd0, bus_if.done},     32'd0);
    chk("reset busy",     {31'd0, bus_if.busy},     32'd0);
    chk("reset norm",     {16'd0, bus_if.norm},     32'd0);
    chk("reset out",      bus_if.out,               32'd0);
    chk("reset overflow", {31'd0, bus_if.overflow}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].mode, vecs[i].var1, vecs[i].nsh, lat, bz_s, bz_d, o, nr, ov, da);
      chk($sformatf("v%0d latency", i),    32'(lat),        32'(vecs[i].exp_lat));
      chk($sformatf("v%0d out", i),        o,               vecs[i].exp_out);
      chk($sformatf("v%0d norm", i),       {16'd0, nr},     {16'd0, vecs[i].exp_norm});
      chk($sformatf("v%0d overflow", i),   {31'd0, ov},     {31'd0, vecs[i].exp_ovf});
      chk($sformatf("v%0d busy start", i), {31'd0, bz_s},   32'd1);
      chk($sformatf("v%0d busy at done", i), {31'd0, bz_d}, 32'd0);
      chk($sformatf("v%0d done width", i), {31'd0, da},     32'd0);
      repeat (2) @(posedge clk);
      #1;
    end

    // ready held high through DONE: accepted again only on the following IDLE edge.
    bus_if.mode     = 1'b1;
    bus_if.var1     = 32'h1234_5678;
    bus_if.numShift = 16'd0;
    bus_if.ready    = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold k+1 busy", {31'd0, bus_if.busy}, 32'd0);
    @(posedge clk); #1;
    chk("hold k+2 done", {31'd0, bus_if.done}, 32'd1);
    chk("hold k+2 busy", {31'd0, bus_if.busy}, 32'd0);
    @(posedge clk); #1;
    bus_if.ready = 1'b0;
    chk("hold k+3 busy", {31'd0, bus_if.busy}, 32'd1);
    chk("hold k+3 done", {31'd0, bus_if.done}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold 2nd done", {31'd0, bus_if.done}, 32'd1);
    chk("hold 2nd out",  bus_if.out,           32'h1234_5678);
    repeat (2) @(posedge clk);
    #1;

    // Reset during an operation aborts it without a done pulse.
    bus_if.mode  = 1'b0;
    bus_if.var1  = 32'h0001_0000;
    bus_if.ready = 1'b1;
    @(posedge clk); #1;
    bus_if.ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort done",     {31'd0, bus_if.done},     32'd0);
    chk("abort busy",     {31'd0, bus_if.busy},     32'd0);
    chk("abort norm",     {16'd0, bus_if.norm},     32'd0);
    chk("abort out",      bus_if.out,               32'd0);
    chk("abort overflow", {31'd0, bus_if.overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus_if.done) extra_done++;
    end
    chk("abort no done", 32'(extra_done), 32'd0);

    // A second request while busy is dropped, not queued.
    bus_if.mode  = 1'b0;
    bus_if.var1  = 32'h0000_0001;
    bus_if.ready = 1'b1;
    @(posedge clk); #1;
    bus_if.ready = 1'b0;
    total = 1;
    @(posedge clk); #1;
    total++;
    bus_if.mode     = 1'b1;
    bus_if.var1     = 32'h0000_0000;
    bus_if.numShift = 16'd5;
    bus_if.ready    = 1'b1;
    @(posedge clk); #1;
    total++;
    bus_if.ready = 1'b0;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus_if.done) begin
        lat = total - 1;
        break;
      end
      @(posedge clk); #1;
      total++;
    end
    chk("busy-ignore latency",  32'(lat),             32'd32);
    chk("busy-ignore norm",     {16'd0, bus_if.norm}, 32'd30);
    chk("busy-ignore out",      bus_if.out,           32'h4000_0000);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus_if.done || bus_if.busy) extra_done++;
    end
    chk("busy-ignore not queued", 32'(extra_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
